// File: rtl/acc_core_pkg.sv
// Shared definitions for the accumulator micro-core: opcode values, FSM states
// and the opcode legality check used by both the FSM and the datapath.
package acc_core_pkg;

  localparam int unsigned OPC_W = 8;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OP_NOP  = 8'h00;
  localparam opcode_t OP_LOAD = 8'h01;
  localparam opcode_t OP_ADD  = 8'h02;
  localparam opcode_t OP_SUB  = 8'h03;
  localparam opcode_t OP_AND  = 8'h04;
  localparam opcode_t OP_OR   = 8'h05;
  localparam opcode_t OP_XOR  = 8'h06;
  localparam opcode_t OP_NOT  = 8'h07;
  localparam opcode_t OP_SHL  = 8'h08;
  localparam opcode_t OP_SHR  = 8'h09;
  localparam opcode_t OP_HALT = 8'h0A;
  localparam opcode_t OP_JMP  = 8'h0B;
  localparam opcode_t OP_JZ   = 8'h0C;
  localparam opcode_t OP_JC   = 8'h0D;
  localparam opcode_t OP_ADC  = 8'h0E;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_OPERAND = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALT    = 3'd4
  } state_e;

  // Opcodes above ADC are undefined and trap the core.
  function automatic logic is_legal(input opcode_t opc);
    return (opc <= OP_ADC);
  endfunction

endpackage

// File: rtl/acc_core_param_if.sv
// Program-load, control and status bundle between the tile wrapper and the core.
interface acc_core_param_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 5
) ();

  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic          run;
  logic [DW-1:0] acc;
  logic [AW-1:0] pc;
  logic          flag_z;
  logic          flag_c;
  logic          busy;
  logic          halted;
  logic          illegal;

  modport master (
    output prog_we, prog_addr, prog_data, run,
    input  acc, pc, flag_z, flag_c, busy, halted, illegal
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, run,
    output acc, pc, flag_z, flag_c, busy, halted, illegal
  );

endinterface

// File: rtl/acc_core_alu.sv
// Combinational ALU: computes the new accumulator and carry for one opcode.
// Ops that do not touch carry pass cin through so the caller can always load it.
module acc_core_alu
  import acc_core_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  opcode_t       opcode,
  input  logic [DW-1:0] acc,
  input  logic [DW-1:0] op,
  input  logic          cin,
  output logic [DW-1:0] result_c,
  output logic          cout_c,
  output logic          write_en_c
);

  localparam int unsigned SW = DW + 1;

  logic [SW-1:0] sum;

  always_comb begin
    sum        = '0;
    result_c   = acc;
    cout_c     = cin;
    write_en_c = 1'b0;
    case (opcode)
      OP_LOAD: begin
        result_c   = op;
        write_en_c = 1'b1;
      end
      OP_ADD: begin
        sum        = {1'b0, acc} + {1'b0, op};
        result_c   = sum[DW-1:0];
        cout_c     = sum[DW];
        write_en_c = 1'b1;
      end
      OP_ADC: begin
        sum        = {1'b0, acc} + {1'b0, op} + SW'(cin);
        result_c   = sum[DW-1:0];
        cout_c     = sum[DW];
        write_en_c = 1'b1;
      end
      // Top bit of the wide difference is the borrow, i.e. acc < op unsigned.
      OP_SUB: begin
        sum        = {1'b0, acc} - {1'b0, op};
        result_c   = sum[DW-1:0];
        cout_c     = sum[DW];
        write_en_c = 1'b1;
      end
      OP_AND: begin
        result_c   = acc & op;
        write_en_c = 1'b1;
      end
      OP_OR: begin
        result_c   = acc | op;
        write_en_c = 1'b1;
      end
      OP_XOR: begin
        result_c   = acc ^ op;
        write_en_c = 1'b1;
      end
      OP_NOT: begin
        result_c   = ~acc;
        write_en_c = 1'b1;
      end
      OP_SHL: begin
        result_c   = {acc[DW-2:0], 1'b0};
        cout_c     = acc[DW-1];
        write_en_c = 1'b1;
      end
      OP_SHR: begin
        result_c   = {1'b0, acc[DW-1:1]};
        cout_c     = acc[0];
        write_en_c = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_core_param.sv
// Parametrised accumulator micro-core: program RAM, fetch/operand/execute FSM,
// accumulator, program counter and Z/C/illegal status.
module acc_core_param
  import acc_core_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  acc_core_param_if.slave     bus
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] mem_rd;

  state_e        state_q, state_d;
  opcode_t       opcode_q, opcode_d;
  logic [DW-1:0] operand_q, operand_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          z_q, z_d;
  logic          c_q, c_d;
  logic          ill_q, ill_d;
  logic          busy_q, busy_d;
  logic          halted_q, halted_d;

  logic [DW-1:0] alu_res_c;
  logic          alu_cout_c;
  logic          alu_we_c;

  acc_core_alu #(.DW(DW)) u_alu (
    .opcode     (opcode_q),
    .acc        (acc_q),
    .op         (operand_q),
    .cin        (c_q),
    .result_c   (alu_res_c),
    .cout_c     (alu_cout_c),
    .write_en_c (alu_we_c)
  );

  // Program memory is not reset so it survives a core reset.
  always_ff @(posedge clk) begin
    if (bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
  end

  assign mem_rd = mem[pc_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A program write freezes the core for that cycle, including a pending run.
  always_comb begin
    state_d = state_q;
    if (!bus.prog_we) begin
      case (state_q)
        ST_IDLE, ST_HALT: if (bus.run) state_d = ST_FETCH;
        ST_FETCH:         state_d = ST_OPERAND;
        ST_OPERAND:       state_d = ST_EXECUTE;
        ST_EXECUTE: begin
          if (opcode_q == OP_HALT || !is_legal(opcode_q)) state_d = ST_HALT;
          else                                            state_d = ST_FETCH;
        end
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    opcode_d  = opcode_q;
    operand_d = operand_q;
    acc_d     = acc_q;
    pc_d      = pc_q;
    z_d       = z_q;
    c_d       = c_q;
    ill_d     = ill_q;
    busy_d    = (state_d == ST_FETCH) || (state_d == ST_OPERAND) || (state_d == ST_EXECUTE);
    halted_d  = (state_d == ST_HALT);
    if (!bus.prog_we) begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (bus.run) begin
            pc_d  = '0;
            acc_d = '0;
            z_d   = 1'b0;
            c_d   = 1'b0;
            ill_d = 1'b0;
          end
        end
        ST_FETCH: begin
          opcode_d = mem_rd[OPC_W-1:0];
          pc_d     = pc_q + AW'(1);
        end
        ST_OPERAND: begin
          operand_d = mem_rd;
          pc_d      = pc_q + AW'(1);
        end
        ST_EXECUTE: begin
          if (alu_we_c) begin
            acc_d = alu_res_c;
            c_d   = alu_cout_c;
            z_d   = (alu_res_c == '0);
          end
          case (opcode_q)
            OP_JMP:  pc_d = operand_q[AW-1:0];
            OP_JZ:   if (z_q) pc_d = operand_q[AW-1:0];
            OP_JC:   if (c_q) pc_d = operand_q[AW-1:0];
            default: ;
          endcase
          if (!is_legal(opcode_q)) ill_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q  <= '0;
      operand_q <= '0;
      acc_q     <= '0;
      pc_q      <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      ill_q     <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      pc_q      <= pc_d;
      z_q       <= z_d;
      c_q       <= c_d;
      ill_q     <= ill_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
    end
  end

  assign bus.acc     = acc_q;
  assign bus.pc      = pc_q;
  assign bus.flag_z  = z_q;
  assign bus.flag_c  = c_q;
  assign bus.busy    = busy_q;
  assign bus.halted  = halted_q;
  assign bus.illegal = ill_q;

endmodule

// File: tb/tb_acc_core_param.sv
// Bench for acc_core_param: directed programs plus random programs on an 8/5
// and a 16/6 build, scored against an instruction-level reference model.
module tb_acc_core_param;
  import acc_core_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  acc_core_param_if #(.DW(8),  .AW(5)) b8();
  acc_core_param_if #(.DW(16), .AW(6)) b16();

  acc_core_param #(.DW(8),  .AW(5)) u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  acc_core_param #(.DW(16), .AW(6)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  typedef struct {
    longint acc;
    int     pc;
    bit     z;
    bit     c;
    bit     ill;
    int     cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int n_tests = 0;
  int n_fail = 0;
  bit [31:0] prog_img [64];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input longint acc, input int pc, input bit z, input bit c,
                              input bit ill, input int cyc);
    exp_t e;
    e.acc = acc; e.pc = pc; e.z = z; e.c = c; e.ill = ill; e.cyc = cyc;
    return e;
  endfunction

  task automatic score(input string tag, input exp_t e, input logic [63:0] acc, input logic [63:0] pc,
                       input logic z, input logic c, input logic ill, input int cyc);
    chk({tag, "_acc"}, acc, 64'(e.acc));
    chk({tag, "_pc"}, pc, 64'(e.pc));
    chk({tag, "_z"}, 64'(z), 64'(e.z));
    chk({tag, "_c"}, 64'(c), 64'(e.c));
    chk({tag, "_illegal"}, 64'(ill), 64'(e.ill));
    chk({tag, "_cycles"}, 64'(cyc), 64'(e.cyc));
  endtask

  // Instruction-level interpreter over prog_img; each instruction costs 3 cycles.
  function automatic exp_t model(input int dw, input int aw, output bit ok);
    longint mask = (longint'(1) << dw) - 1;
    int depth = 1 << aw;
    longint acc = 0, op, t;
    int pc = 0, n = 0, opc;
    bit z = 0, c = 0, ill = 0;
    ok = 0;
    while (n < 1000) begin
      opc = int'(prog_img[pc] & 32'hFF);
      pc = (pc + 1) % depth;
      op = longint'(prog_img[pc]) & mask;
      pc = (pc + 1) % depth;
      n++;
      if (opc == 10) begin ok = 1; break; end
      if (opc > 14) begin ill = 1; ok = 1; break; end
      case (opc)
        1:  acc = op;
        2:  begin t = acc + op; c = t > mask; acc = t & mask; end
        3:  begin c = acc < op; acc = (acc - op) & mask; end
        4:  acc = acc & op;
        5:  acc = acc | op;
        6:  acc = acc ^ op;
        7:  acc = ~acc & mask;
        8:  begin c = ((acc >> (dw - 1)) & 1) != 0; acc = (acc << 1) & mask; end
        9:  begin c = (acc & 1) != 0; acc = acc >> 1; end
        11: pc = int'(op % depth);
        12: if (z) pc = int'(op % depth);
        13: if (c) pc = int'(op % depth);
        14: begin t = acc + op + longint'(c); c = t > mask; acc = t & mask; end
        default: ;
      endcase
      if (opc inside {[1:9], 14}) z = (acc == 0);
    end
    return mk(acc, pc, z, c, ill, 3 * n);
  endfunction

  task automatic clr_img();
    foreach (prog_img[i]) prog_img[i] = '0;
  endtask

  task automatic put(input int a, input int opc, input longint op);
    prog_img[a]     = 32'(opc);
    prog_img[a + 1] = 32'(op);
  endtask

  task automatic write_word(input bit sel, input int a, input bit [31:0] d);
    @(negedge clk);
    if (sel) begin
      b16.prog_we = 1'b1; b16.prog_addr = 6'(a); b16.prog_data = 16'(d);
    end else begin
      b8.prog_we = 1'b1; b8.prog_addr = 5'(a); b8.prog_data = 8'(d);
    end
    @(negedge clk);
    b8.prog_we = 1'b0;
    b16.prog_we = 1'b0;
  endtask

  task automatic load(input bit sel);
    int depth = sel ? 64 : 32;
    for (int i = 0; i < depth; i++) write_word(sel, i, prog_img[i]);
  endtask

  task automatic start_run(input bit sel);
    @(negedge clk);
    if (sel) b16.run = 1'b1; else b8.run = 1'b1;
    @(negedge clk);
    b8.run = 1'b0;
    b16.run = 1'b0;
  endtask

  task automatic wait_halt(input bit sel);
    int i = 0;
    while (!(sel ? b16.halted : b8.halted) && i < 4000) begin
      @(negedge clk);
      i++;
    end
    if (!(sel ? b16.halted : b8.halted)) chk("halt_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic gen_rand(input bit sel);
    int depth = sel ? 64 : 32;
    longint mask = sel ? 64'hFFFF : 64'hFF;
    clr_img();
    for (int a = 0; a < depth - 2; a += 2) begin
      int r = int'($urandom_range(0, 99));
      int opc;
      longint op = longint'($urandom) & mask;
      if (r < 4) opc = int'($urandom_range(15, 255));
      else       opc = int'($urandom_range(0, 14));
      if (opc inside {11, 12, 13}) op = longint'(2 * $urandom_range((a + 2) / 2, (depth - 2) / 2));
      prog_img[a]     = 32'(opc) | ((32'($urandom) << 8) & 32'(mask));
      prog_img[a + 1] = 32'(op);
    end
    prog_img[depth - 2] = 32'(OP_HALT);
  endtask

  task automatic run_rand(input bit sel);
    bit ok;
    exp_t e;
    gen_rand(sel);
    load(sel);
    e = model(sel ? 16 : 8, sel ? 6 : 5, ok);
    if (ok) begin
      if (sel) q16.push_back(e); else q8.push_back(e);
      start_run(sel);
      wait_halt(sel);
    end
  endtask

  task automatic prog_basic();
    clr_img();
    put(0, OP_LOAD, 'hFF);
    put(2, OP_ADD, 1);
    put(4, OP_HALT, 0);
  endtask

  // Monitors: count busy cycles and score each transition into halted.
  initial begin : mon8
    int cnt = 0;
    bit prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        cnt = 0; prev = 1'b0;
      end else begin
        if (b8.busy) cnt++;
        if (b8.halted && !prev) begin
          if (q8.size() == 0) chk("mon8_unexpected_halt", 64'd1, 64'd0);
          else score("dut8", q8.pop_front(), 64'(b8.acc), 64'(b8.pc), b8.flag_z, b8.flag_c,
                     b8.illegal, cnt);
          cnt = 0;
        end
        prev = b8.halted;
      end
    end
  end

  initial begin : mon16
    int cnt = 0;
    bit prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        cnt = 0; prev = 1'b0;
      end else begin
        if (b16.busy) cnt++;
        if (b16.halted && !prev) begin
          if (q16.size() == 0) chk("mon16_unexpected_halt", 64'd1, 64'd0);
          else score("dut16", q16.pop_front(), 64'(b16.acc), 64'(b16.pc), b16.flag_z, b16.flag_c,
                     b16.illegal, cnt);
          cnt = 0;
        end
        prev = b16.halted;
      end
    end
  end

  initial begin : stim
    b8.prog_we = 1'b0; b8.prog_addr = '0; b8.prog_data = '0; b8.run = 1'b0;
    b16.prog_we = 1'b0; b16.prog_addr = '0; b16.prog_data = '0; b16.run = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_acc", 64'(b8.acc), 64'd0);
    chk("rst_pc", 64'(b8.pc), 64'd0);
    chk("rst_z", 64'(b8.flag_z), 64'd0);
    chk("rst_c", 64'(b8.flag_c), 64'd0);
    chk("rst_illegal", 64'(b8.illegal), 64'd0);
    chk("rst_busy", 64'(b8.busy), 64'd0);
    chk("rst_halted", 64'(b8.halted), 64'd0);
    chk("rst_busy16", 64'(b16.busy), 64'd0);
    rst_n = 1'b1;

    // 0xFF + 1 wraps to zero with carry out
    prog_basic();
    load(0);
    q8.push_back(mk(0, 6, 1, 1, 0, 9));
    start_run(0);
    wait_halt(0);

    // borrow from 3-5 makes JC taken, skipping the LOAD at 6
    clr_img();
    put(0, OP_LOAD, 3); put(2, OP_SUB, 5); put(4, OP_JC, 8); put(6, OP_LOAD, 'h55); put(8, OP_HALT, 0);
    load(0);
    q8.push_back(mk('hFE, 10, 0, 1, 0, 12));
    start_run(0);
    wait_halt(0);

    // countdown loop: three passes through SUB/JZ
    clr_img();
    put(0, OP_LOAD, 3); put(2, OP_SUB, 1); put(4, OP_JZ, 8); put(6, OP_JMP, 2); put(8, OP_HALT, 0);
    load(0);
    q8.push_back(mk(0, 10, 1, 0, 0, 30));
    start_run(0);
    wait_halt(0);

    // undefined opcode traps, then a fresh run clears the sticky flag
    clr_img();
    put(0, 'h3F, 0);
    load(0);
    q8.push_back(mk(0, 2, 0, 0, 1, 3));
    start_run(0);
    wait_halt(0);
    prog_basic();
    load(0);
    q8.push_back(mk(0, 6, 1, 1, 0, 9));
    start_run(0);
    chk("rerun_illegal_cleared", 64'(b8.illegal), 64'd0);
    chk("rerun_busy", 64'(b8.busy), 64'd1);
    wait_halt(0);

    // program write during OPERAND freezes the core for one cycle
    clr_img();
    put(0, OP_LOAD, 5); put(2, OP_ADD, 7); put(4, OP_HALT, 0);
    load(0);
    q8.push_back(mk(14, 6, 0, 0, 0, 10));
    start_run(0);
    @(negedge clk);
    chk("operand_pc_before_we", 64'(b8.pc), 64'd1);
    b8.prog_we = 1'b1; b8.prog_addr = 5'd3; b8.prog_data = 8'd9;
    @(negedge clk);
    b8.prog_we = 1'b0;
    chk("we_freeze_pc", 64'(b8.pc), 64'd1);
    chk("we_freeze_busy", 64'(b8.busy), 64'd1);
    @(negedge clk);
    chk("after_we_pc", 64'(b8.pc), 64'd2);
    wait_halt(0);

    // reset in EXECUTE of the ADD aborts; memory survives for the rerun
    prog_basic();
    load(0);
    start_run(0);
    repeat (5) @(negedge clk);
    chk("mid_acc", 64'(b8.acc), 64'hFF);
    chk("mid_pc", 64'(b8.pc), 64'd4);
    rst_n = 1'b0;
    #1;
    chk("abort_acc", 64'(b8.acc), 64'd0);
    chk("abort_pc", 64'(b8.pc), 64'd0);
    chk("abort_busy", 64'(b8.busy), 64'd0);
    chk("abort_halted", 64'(b8.halted), 64'd0);
    chk("abort_c", 64'(b8.flag_c), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    q8.push_back(mk(0, 6, 1, 1, 0, 9));
    start_run(0);
    wait_halt(0);

    repeat (12) run_rand(0);

    // 16/6 build: ADD at 62 leaves pc wrapping 63 -> 0, where JC is now taken
    clr_img();
    put(0, OP_JC, 4); put(2, OP_JMP, 60); put(4, OP_HALT, 0);
    put(60, OP_LOAD, 'hFFFF); put(62, OP_ADD, 1);
    load(1);
    q16.push_back(mk(0, 6, 1, 1, 0, 18));
    start_run(1);
    wait_halt(1);

    repeat (6) run_rand(1);

    repeat (5) @(negedge clk);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    chk("q16_drained", 64'(q16.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
